// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - state encoding and ALU_FUN group codes shared with the ALU decoder
package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_A    = 3'd1,
        ST_GET_B    = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_SEND_LO  = 3'd5,
        ST_SEND_HI  = 3'd6
    } state_t;

    localparam logic [3:0] HEADER_DEFAULT = 4'hA;

    localparam logic [1:0] FUN_ARITH = 2'b00;
    localparam logic [1:0] FUN_LOGIC = 2'b01;
    localparam logic [1:0] FUN_CMP   = 2'b10;
    localparam logic [1:0] FUN_SHIFT = 2'b11;

    // Only frame collection accepts receive bytes; everything later is busy.
    function automatic logic is_busy_state(input state_t s);
        return !(s == ST_IDLE || s == ST_GET_A || s == ST_GET_B);
    endfunction

endpackage

// File: rtl/alu_ctrl_wdog.sv
// rtl/alu_ctrl_wdog.sv - result timeout counter with clear, enable and expire
module alu_ctrl_wdog #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] count_q;

    // Expire on the LIMIT-th enabled cycle so the waiting state lasts exactly LIMIT cycles.
    assign expire = en && (count_q == (LIMIT - 8'd1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= 8'd0;
        end else if (en && !expire) begin
            count_q <= count_q + 8'd1;
        end
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - ALU command front-end; ALU_CMD_CTRL_TIMEOUT_EN adds the result timeout
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter logic [3:0] HEADER = HEADER_DEFAULT
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_P_DATA,
    input  logic        RX_D_VLD,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output logic [3:0]  ALU_FUN,
    output logic        ALU_EN,
    input  logic [15:0] ALU_OUT,
    input  logic        ALU_OUT_VLD,
    output logic [7:0]  TX_P_DATA,
    output logic        TX_D_VLD,
    input  logic        TX_BUSY,
    output logic        BUSY,
    output logic        FRAME_ERR,
    output logic        OVERRUN,
    output logic        RESULT_TO
);

    state_t      state_q, state_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  alu_a_d, alu_b_d, tx_data_d;
    logic [3:0]  alu_fun_d;
    logic        alu_en_d, tx_vld_d, frame_err_d, overrun_d, result_to_d;
    logic        to_expire;

`ifdef ALU_CMD_CTRL_TIMEOUT_EN
    logic wd_clr, wd_en;

    alu_ctrl_wdog #(
        .LIMIT(8'(TIMEOUT_CYCLES))
    ) u_wdog (
        .clk    (CLK),
        .rst    (RST),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (to_expire)
    );
`else
    assign to_expire = 1'b0;
    assign RESULT_TO = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        alu_a_d     = ALU_A;
        alu_b_d     = ALU_B;
        alu_fun_d   = ALU_FUN;
        alu_en_d    = 1'b0;
        tx_data_d   = TX_P_DATA;
        tx_vld_d    = TX_D_VLD;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        result_to_d = 1'b0;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
        wd_clr      = 1'b0;
        wd_en       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA[7:4] == HEADER) begin
                        alu_fun_d = RX_P_DATA[3:0];
                        state_d   = ST_GET_A;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            ST_GET_A: begin
                if (RX_D_VLD) begin
                    alu_a_d = RX_P_DATA;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (RX_D_VLD) begin
                    alu_b_d  = RX_P_DATA;
                    alu_en_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
                wd_clr = 1'b1;
`endif
                state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
                wd_en = 1'b1;
`endif
                // A result arriving on the expiry cycle still wins.
                if (ALU_OUT_VLD) begin
                    result_d  = ALU_OUT;
                    tx_data_d = ALU_OUT[7:0];
                    tx_vld_d  = 1'b1;
                    state_d   = ST_SEND_LO;
                end else if (to_expire) begin
                    result_to_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_SEND_LO: begin
                if (!TX_BUSY) begin
                    tx_data_d = result_q[15:8];
                    state_d   = ST_SEND_HI;
                end
            end
            ST_SEND_HI: begin
                if (!TX_BUSY) begin
                    tx_vld_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (RX_D_VLD && is_busy_state(state_q)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            result_q  <= 16'd0;
            ALU_A     <= 8'd0;
            ALU_B     <= 8'd0;
            ALU_FUN   <= 4'd0;
            ALU_EN    <= 1'b0;
            TX_P_DATA <= 8'd0;
            TX_D_VLD  <= 1'b0;
            BUSY      <= 1'b0;
            FRAME_ERR <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            ALU_A     <= alu_a_d;
            ALU_B     <= alu_b_d;
            ALU_FUN   <= alu_fun_d;
            ALU_EN    <= alu_en_d;
            TX_P_DATA <= tx_data_d;
            TX_D_VLD  <= tx_vld_d;
            BUSY      <= is_busy_state(state_d);
            FRAME_ERR <= frame_err_d;
            OVERRUN   <= overrun_d;
        end
    end

`ifdef ALU_CMD_CTRL_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            RESULT_TO <= 1'b0;
        end else begin
            RESULT_TO <= result_to_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl with frame/result scoreboard
module tb_alu_cmd_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  RX_P_DATA = 8'd0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, TX_D_VLD, BUSY, FRAME_ERR, OVERRUN, RESULT_TO;
    logic [15:0] ALU_OUT = 16'd0;
    logic        ALU_OUT_VLD = 1'b0;
    logic        TX_BUSY = 1'b0;

    int checks = 0;
    int failures = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    logic [19:0] exp_issue[$];
    logic [7:0]  exp_tx[$];

    always #5 CLK = ~CLK;

    alu_cmd_ctrl #(
        .HEADER(4'hA)
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_P_DATA   (RX_P_DATA),
        .RX_D_VLD    (RX_D_VLD),
        .ALU_A       (ALU_A),
        .ALU_B       (ALU_B),
        .ALU_FUN     (ALU_FUN),
        .ALU_EN      (ALU_EN),
        .ALU_OUT     (ALU_OUT),
        .ALU_OUT_VLD (ALU_OUT_VLD),
        .TX_P_DATA   (TX_P_DATA),
        .TX_D_VLD    (TX_D_VLD),
        .TX_BUSY     (TX_BUSY),
        .BUSY        (BUSY),
        .FRAME_ERR   (FRAME_ERR),
        .OVERRUN     (OVERRUN),
        .RESULT_TO   (RESULT_TO)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
    endtask

    // Model: a frame issues {fun, a, b}; a result returns low byte then high byte.
    task automatic send_frame(input logic [7:0] hdr, input logic [7:0] a, input logic [7:0] b);
        exp_issue.push_back({hdr[3:0], a, b});
        send_byte(hdr);
        send_byte(a);
        send_byte(b);
        check("alu_en_after_b", 32'(ALU_EN), 32'(1));
        tick();
        check("alu_en_single", 32'(ALU_EN), 32'(0));
        check("busy_wait_res", 32'(BUSY), 32'(1));
    endtask

    task automatic respond(input logic [15:0] r, input int delay);
        for (int i = 0; i < delay; i++) tick();
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
        ALU_OUT     = r;
        ALU_OUT_VLD = 1'b1;
        tick();
        ALU_OUT_VLD = 1'b0;
        ALU_OUT     = 16'hDEAD;
        check("tx_vld_after_result", 32'(TX_D_VLD), 32'(1));
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 50; i++) begin
            if (exp_tx.size() == 0) break;
            tick();
        end
        check("tx_drain_remaining", 32'(exp_tx.size()), 32'(0));
        check("tx_vld_low_after", 32'(TX_D_VLD), 32'(0));
        check("busy_low_after", 32'(BUSY), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_alu_a"}, 32'(ALU_A), 32'(0));
        check({tag, "_alu_b"}, 32'(ALU_B), 32'(0));
        check({tag, "_alu_fun"}, 32'(ALU_FUN), 32'(0));
        check({tag, "_alu_en"}, 32'(ALU_EN), 32'(0));
        check({tag, "_tx_data"}, 32'(TX_P_DATA), 32'(0));
        check({tag, "_tx_vld"}, 32'(TX_D_VLD), 32'(0));
        check({tag, "_busy"}, 32'(BUSY), 32'(0));
        check({tag, "_errs"}, 32'({FRAME_ERR, OVERRUN, RESULT_TO}), 32'(0));
    endtask

    logic [19:0] e_issue;
    logic [7:0]  e_tx;
    logic [7:0]  prev_data;
    logic        prev_vld = 1'b0, prev_busy = 1'b0, prev_rst = 1'b1;
    logic        prev_fe = 1'b0, prev_ov = 1'b0;

    always @(negedge CLK) begin
        if (!RST) begin
            if (ALU_EN) begin
                if (exp_issue.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_alu_en: got ALU_EN=1 with no frame pending");
                end else begin
                    e_issue = exp_issue.pop_front();
                    check("issue_fun_a_b", 32'({ALU_FUN, ALU_A, ALU_B}), 32'(e_issue));
                end
            end
            if (TX_D_VLD && !TX_BUSY) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_tx: got byte 0x%0h with none pending", TX_P_DATA);
                end else begin
                    e_tx = exp_tx.pop_front();
                    check("tx_byte", 32'(TX_P_DATA), 32'(e_tx));
                end
            end
            if (prev_vld && prev_busy && !prev_rst) begin
                check("tx_hold_vld", 32'(TX_D_VLD), 32'(1));
                check("tx_hold_data", 32'(TX_P_DATA), 32'(prev_data));
            end
            if (FRAME_ERR) begin
                fe_cnt++;
                if (prev_fe) check("frame_err_width", 32'(2), 32'(1));
            end
            if (OVERRUN) begin
                ov_cnt++;
                if (prev_ov) check("overrun_width", 32'(2), 32'(1));
            end
        end
        prev_vld  = TX_D_VLD;
        prev_busy = TX_BUSY;
        prev_data = TX_P_DATA;
        prev_rst  = RST;
        prev_fe   = FRAME_ERR;
        prev_ov   = OVERRUN;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        RST = 1'b0;
        tick();

        // Basic frame, literal expectations pin the model
        send_frame(8'hA3, 8'h12, 8'h34);
        check("t1_fun", 32'(ALU_FUN), 32'(4'h3));
        check("t1_a", 32'(ALU_A), 32'(8'h12));
        check("t1_b", 32'(ALU_B), 32'(8'h34));
        respond(16'h0046, 2);
        check("t1_lo_byte", 32'(TX_P_DATA), 32'(8'h46));
        drain();

        // Bad header, then a good frame
        send_byte(8'h53);
        check("t2_frame_err", 32'(FRAME_ERR), 32'(1));
        check("t2_busy", 32'(BUSY), 32'(0));
        tick();
        check("t2_frame_err_clear", 32'(FRAME_ERR), 32'(0));
        send_frame(8'hA0, 8'h05, 8'h07);
        check("t2_fun", 32'(ALU_FUN), 32'(4'h0));
        respond(16'h000C, 0);
        drain();

        // Transmitter backpressure during the low byte
        send_frame(8'hA5, 8'h10, 8'h20);
        TX_BUSY = 1'b1;
        respond(16'hBEEF, 3);
        for (int i = 0; i < 10; i++) begin
            check("t3_lo_held", 32'(TX_P_DATA), 32'(8'hEF));
            tick();
        end
        TX_BUSY = 1'b0;
        tick();
        check("t3_hi_byte", 32'(TX_P_DATA), 32'(8'hBE));
        check("t3_hi_vld", 32'(TX_D_VLD), 32'(1));
        drain();

        // Byte arriving while waiting for the result
        send_frame(8'hA6, 8'h11, 8'h22);
        send_byte(8'h99);
        check("t4_overrun", 32'(OVERRUN), 32'(1));
        check("t4_busy", 32'(BUSY), 32'(1));
        check("t4_operands", 32'({ALU_FUN, ALU_A, ALU_B}), 32'(20'h61122));
        tick();
        check("t4_overrun_clear", 32'(OVERRUN), 32'(0));
        respond(16'h1234, 1);
        drain();

        // No result from the ALU
        send_frame(8'hA8, 8'h01, 8'h02);
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
        for (int c = 3; c <= 18; c++) begin
            tick();
            check("t5_result_to", 32'(RESULT_TO), 32'(c == 18));
        end
        check("t5_busy_idle", 32'(BUSY), 32'(0));
        tick();
        check("t5_result_to_clear", 32'(RESULT_TO), 32'(0));
        check("t5_no_tx", 32'(TX_D_VLD), 32'(0));
`else
        for (int c = 0; c < 98; c++) tick();
        check("t5_still_busy", 32'(BUSY), 32'(1));
        check("t5_no_tx", 32'(TX_D_VLD), 32'(0));
        check("t5_no_result_to", 32'(RESULT_TO), 32'(0));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        check("t5_busy_after_rst", 32'(BUSY), 32'(0));
`endif

        // Reset in the middle of a frame
        send_byte(8'hA2);
        send_byte(8'h33);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_reset_outputs("midrst");
        send_byte(8'h34);
        check("t6_frame_err", 32'(FRAME_ERR), 32'(1));
        tick();
        tick();
        check("t6_no_tx", 32'(TX_D_VLD), 32'(0));

        check("frame_err_total", 32'(fe_cnt), 32'(2));
        check("overrun_total", 32'(ov_cnt), 32'(1));
        check("issue_queue_empty", 32'(exp_issue.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
# alu_cmd_ctrl

Command front-end for the ALU: collects a three-byte command frame (header/function, operand A, operand B) from the receive byte stream, drives ALU_FUN, operands and a one-cycle ALU_EN into the ALU (whose decoder splits ALU_FUN[3:2] into Arith/Logic/CMP/Shift enables), waits for the result, then returns the 16-bit result as two bytes on the transmit byte stream. Sits directly upstream of the ALU decoder and downstream of the serial receiver.

## Interface
- HEADER, 4'hA: required value of command byte bits [7:4].
- TIMEOUT_CYCLES, 255: maximum WAIT_RES cycles (only used with the timeout feature); 8-bit range, minimum 1.
- CLK  in  1  single clock, all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- RX_P_DATA  in  8  received byte.
- RX_D_VLD  in  1  RX_P_DATA valid this cycle (single-cycle strobe, no backpressure).
- ALU_A, ALU_B  out  8  operands to ALU.
- ALU_FUN  out  4  function; [3:2] group (00 arith, 01 logic, 10 cmp, 11 shift), [1:0] op.
- ALU_EN  out  1  one-cycle issue strobe.
- ALU_OUT  in  16  ALU result.
- ALU_OUT_VLD  in  1  ALU_OUT valid strobe.
- TX_P_DATA  out  8  byte to transmitter.
- TX_D_VLD  out  1  TX_P_DATA valid; held until accepted.
- TX_BUSY  in  1  transmitter cannot accept; byte accepted when TX_D_VLD=1 and TX_BUSY=0.
- BUSY  out  1  high in every state except IDLE, GET_A, GET_B.
- FRAME_ERR  out  1  one-cycle pulse: bad header byte.
- OVERRUN  out  1  one-cycle pulse: RX byte arrived while BUSY.
- RESULT_TO  out  1  one-cycle pulse: result timeout (feature only).

## Operation
- States: IDLE, GET_A, GET_B, ISSUE, WAIT_RES, SEND_LO, SEND_HI.
- IDLE: on RX_D_VLD, if RX_P_DATA[7:4]==HEADER latch ALU_FUN<=RX_P_DATA[3:0], go GET_A; else pulse FRAME_ERR, stay IDLE.
- GET_A: on RX_D_VLD latch ALU_A, go GET_B. GET_B: on RX_D_VLD latch ALU_B, go ISSUE. No inter-byte timeout.
- ISSUE: ALU_EN=1 for exactly this cycle, go WAIT_RES.
- WAIT_RES: on ALU_OUT_VLD capture ALU_OUT into result register, go SEND_LO. ALU_OUT_VLD ignored in all other states.
- SEND_LO: TX_D_VLD=1, TX_P_DATA=result[7:0]; on acceptance go SEND_HI. SEND_HI: same with result[15:8]; on acceptance go IDLE, TX_D_VLD low next cycle.
- RX_D_VLD in ISSUE..SEND_HI: byte dropped, OVERRUN pulses next cycle, state unaffected.
- ALU_A/ALU_B/ALU_FUN hold last latched values until overwritten by next frame.
- Result width fixed 16 bits; no arithmetic performed here.

## Timing
- All outputs registered. Reset: state IDLE, ALU_A=ALU_B=0, ALU_FUN=0, ALU_EN=0, TX_P_DATA=0, TX_D_VLD=0, BUSY=0, FRAME_ERR=OVERRUN=RESULT_TO=0, result register 0, timeout counter 0.
- B byte accepted at edge n: ALU_EN=1 during cycle n+1, WAIT_RES from n+2.
- ALU_OUT_VLD sampled at edge m: TX_D_VLD=1 with low byte from cycle m+1; high byte from cycle after low byte acceptance. Minimum frame-to-first-TX latency 3 cycles plus ALU latency.
- TX_P_DATA stable while TX_D_VLD=1 and TX_BUSY=1.
- Error pulses one cycle wide, asserted the cycle after the causing RX_D_VLD.
- RST mid-frame aborts immediately; partial frame and pending result discarded, no TX byte emitted after reset.

## Configuration
- ALU_CMD_CTRL_TIMEOUT_EN defined: counter clears on entry to WAIT_RES, increments each WAIT_RES cycle; when it reaches TIMEOUT_CYCLES without ALU_OUT_VLD, RESULT_TO pulses and state returns IDLE with no TX. ALU_OUT_VLD on the expiry cycle wins (result captured, no RESULT_TO).
- Not defined: WAIT_RES waits indefinitely; RESULT_TO tied 0; counter not instantiated.

## Structure
- Package alu_ctrl_pkg: state encoding, HEADER default, ALU_FUN group codes (ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11) shared with the ALU decoder.
- One sub-module: alu_ctrl_wdog (timeout counter with clear/enable/expire), instantiated only under ALU_CMD_CTRL_TIMEOUT_EN.

## Test plan
- RX 0xA3,0x12,0x34 -> ALU_FUN=4'h3, ALU_A=0x12, ALU_B=0x34, single ALU_EN pulse; ALU_OUT=0x0046 with VLD -> TX bytes 0x46 then 0x00, BUSY low after.
- RX 0x53 in IDLE -> FRAME_ERR one pulse, state IDLE; following 0xA0,0x05,0x07 frame processes normally.
- TX_BUSY high 10 cycles during SEND_LO with result 0xBEEF -> TX_P_DATA=0xEF, TX_D_VLD held stable; 0xBE sent after release.
- RX byte during WAIT_RES -> OVERRUN pulse, no state change; ALU operands unchanged.
- With macro, TIMEOUT_CYCLES=16, no ALU_OUT_VLD -> RESULT_TO after 16 WAIT_RES cycles, IDLE, TX_D_VLD never high; without macro -> still WAIT_RES at cycle 100.
- RST during GET_B -> all outputs reset values; next RX byte 0x34 treated as header -> FRAME_ERR.
